// File: rtl/huff_pkg.sv
// rtl/huff_pkg.sv - shared Huffman decoder constants, chunker state enum and bit-reverse helper
package huff_pkg;

    localparam int HUFF_CHUNK_W_MAX = 4;
    localparam int HUFF_LEN_W       = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        EMIT  = 2'd1,
        DONE  = 2'd2
    } chunker_state_t;

    function automatic logic [7:0] bit_reverse8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = d[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/huff_bit_chunker.sv
// rtl/huff_bit_chunker.sv - slices framed bytes into chunks of up to CHUNK_W bits for the Huffman decoder
// Optional macro HUFF_CHUNKER_LSB_FIRST_EN: bit-reverse each byte so the stream is LSB-first.
module huff_bit_chunker
    import huff_pkg::*;
#(
    parameter int CHUNK_W = 4,
    parameter int BYTE_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [BYTE_W-1:0]     s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    input  logic [3:0]            s_last_bits,
    output logic                  s_ready,
    output logic [3:0]            out_bits,
    output logic [HUFF_LEN_W-1:0] out_len,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  frame_done
);

    localparam logic [3:0] CW     = 4'(CHUNK_W);
    localparam logic [3:0] BYTE_N = 4'(BYTE_W);

    chunker_state_t    state, state_nx;
    logic [BYTE_W-1:0] buf_q;
    logic [3:0]        rem_q;
    logic              last_q;

    logic [BYTE_W-1:0] byte_in;
    logic [3:0]        rem_in;
    logic [3:0]        len;
    logic              accept;
    logic              xfer;

`ifdef HUFF_CHUNKER_LSB_FIRST_EN
    assign byte_in = bit_reverse8(s_data);
`else
    assign byte_in = s_data;
`endif

    // 0 and anything above a full byte both mean "all 8 bits valid"
    assign rem_in = (s_last && s_last_bits != 4'd0 && s_last_bits <= BYTE_N) ? s_last_bits : BYTE_N;
    assign len    = (rem_q > CW) ? CW : rem_q;
    assign accept = (state == EMPTY) && s_valid;
    assign xfer   = (state == EMIT) && out_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= EMPTY;
            buf_q  <= '0;
            rem_q  <= '0;
            last_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                buf_q  <= byte_in;
                rem_q  <= rem_in;
                last_q <= s_last;
            end else if (xfer) begin
                buf_q <= buf_q << len;
                rem_q <= rem_q - len;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        s_ready    = 1'b0;
        out_valid  = 1'b0;
        out_bits   = '0;
        out_len    = '0;
        out_last   = 1'b0;
        frame_done = 1'b0;
        case (state)
            EMPTY: begin
                // held low during reset so no byte appears accepted while reset_n is asserted
                s_ready = reset_n;
                if (s_valid) state_nx = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                out_bits  = 4'(buf_q >> (BYTE_N - len));
                out_len   = len[HUFF_LEN_W-1:0];
                out_last  = last_q && (rem_q <= CW);
                if (out_ready && rem_q == len) state_nx = last_q ? DONE : EMPTY;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nx   = EMPTY;
            end
            default: state_nx = EMPTY;
        endcase
    end

endmodule

// File: doc/huff_bit_chunker.md
# huff_bit_chunker

Upstream feeder for the Huffman decoder. Accepts the compressed stream as bytes over a valid/ready handshake and slices each byte, MSB-first, into chunks of up to `CHUNK_W` bits. Chunks are presented as right-aligned bits plus a length, gated by the decoder's ready signal, so the decoder's bit buffer never overflows. Frames are delimited by a last-byte flag with a partial-bit count, and a one-cycle pulse marks the end of each frame.

## Interface
- `CHUNK_W`, 4: maximum bits per output chunk, legal range 1..4.
- `BYTE_W`, 8: input word width, fixed at 8.
- `clk` input 1: sole clock, rising edge.
- `reset_n` input 1: synchronous, active-low reset, sampled on `clk`.
- `s_data` input 8: compressed byte.
- `s_valid` input 1: `s_data`, `s_last` and `s_last_bits` are valid.
- `s_last` input 1: this byte is the final byte of the frame.
- `s_last_bits` input 4: number of valid MSB-aligned bits in the last byte, 1..8. The value 0 means 8. Ignored unless `s_last` is set.
- `s_ready` output 1: byte accepted when `s_valid && s_ready`.
- `out_bits` output 4: chunk, right-aligned; `out_bits[out_len-1]` is the earliest stream bit; bits above `out_len` are 0.
- `out_len` output 3: chunk length, 1..`CHUNK_W`.
- `out_valid` output 1: chunk valid (drives decoder `sValid`).
- `out_ready` input 1: decoder can accept (decoder `aready`); chunk transfers when `out_valid && out_ready`.
- `out_last` output 1: chunk is the final chunk of the frame.
- `frame_done` output 1: one-cycle pulse, the cycle after the last chunk transfers.

## Operation
- State machine:
  - `EMPTY`: `s_ready=1`, `out_valid=0`. On byte accept: latch the byte into `buf[7:0]` and set `rem` = 8, or `s_last_bits` if `s_last`. Latch `last_q=s_last`. Go to `EMIT`.
  - `EMIT`: `out_valid=1`, `s_ready=0`.
    - `len = min(rem, CHUNK_W)`.
    - `out_bits = buf[7:8-len]`, right-aligned.
    - `out_last = last_q && (rem <= CHUNK_W)`.
    - On transfer: `buf <= buf << len` and `rem <= rem - len`. If `rem - len == 0`, go to `EMPTY`, or to `DONE` if `last_q`.
  - `DONE`: `frame_done=1`, `s_ready=0`, `out_valid=0` for exactly one cycle, then `EMPTY`.
- Width rules:
  - `rem` is 4 bits, range 0..8.
  - The `len` computation never exceeds `CHUNK_W`; `out_len` is never 0 while `out_valid` is high.
- Outputs are registered or decoded from registered state only. There is no combinational path from `out_ready` or `s_valid` to any output.
- Backpressure: while `out_valid && !out_ready`, `out_bits`, `out_len` and `out_last` hold stable.
- A `s_last_bits` value above 8 is clamped to 8.

## Timing
- Reset (`reset_n` low at a `clk` edge) returns to `EMPTY` and sets:
  - `buf=0`, `rem=0`, `last_q=0`
  - `out_valid=0`, `out_bits=0`, `out_len=0`, `out_last=0`, `frame_done=0`
  - `s_ready=0` while `reset_n` is low; 1 on the first cycle after release.
- Reset mid-frame discards buffered bits. No chunk or `frame_done` follows.
- Latency: a byte accepted at edge N gives `out_valid` high after edge N.
- With `CHUNK_W=4` and `out_ready` held high, a full byte takes 2 chunk cycles plus 1 `EMPTY` cycle, so one byte per 3 cycles.
- A byte is never accepted in the same cycle a chunk transfers. This simplicity is decided; throughput is sufficient for the decoder.

## Configuration
- Macro: `HUFF_CHUNKER_LSB_FIRST_EN`.
- Defined: each latched byte is bit-reversed before slicing, so stream order is LSB-first. A partial last byte then uses its low `s_last_bits` bits.
- Undefined: MSB-first as described above.
- All other behaviour is identical in both builds.

## Structure
- Shared package `huff_pkg` holds:
  - constants `HUFF_CHUNK_W_MAX=4` and `HUFF_LEN_W=3`
  - the state enum `chunker_state_t {EMPTY, EMIT, DONE}`
- The decoder uses `HUFF_LEN_W` for its input length port.
- No sub-module. An optional `bit_reverse8` function lives in `huff_pkg` for the LSB-first build.

## Test plan
- `CHUNK_W=4`, byte 0xB4, `s_last=0`, `out_ready=1` -> chunks (0xB,4) then (0x4,4), `out_last=0`, `s_ready` returns high.
- `CHUNK_W=4`, byte 0xA0, `s_last=1`, `s_last_bits=3` -> single chunk (0x5,3), `out_last=1`, `frame_done` pulses the next cycle.
- `CHUNK_W=3`, byte 0xFF with `s_last=1`, `s_last_bits=0` -> (0x7,3), (0x7,3), (0x3,2 with `out_last=1`), then `frame_done`.
- Byte 0xB4 with `out_ready` low for 5 cycles -> (0xB,4) held stable for all 5 cycles, transfers on the first ready cycle, no chunk lost or duplicated.
- `reset_n` low for one cycle after the first chunk of 0xB4 transfers -> `out_valid=0` and `frame_done=0` afterwards, then a fresh byte 0x3C yields (0x3,4), (0xC,4).
- `HUFF_CHUNKER_LSB_FIRST_EN` defined, byte 0xB4 -> chunks (0x2,4) then (0xD,4).
